// File: rtl/jtframe_rom_fetch.sv
// rtl/jtframe_rom_fetch.sv - two-entry line cache between a CPU ROM port and an SDRAM read slot
module jtframe_rom_fetch #(
    parameter int AW = 16,
    parameter int DW = 8,
    parameter int SW = 22
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic [SW-1:0] offset,
    input  logic [AW-1:0] addr,
    input  logic          addr_ok,
    output logic [DW-1:0] dout,
    output logic          data_ok,
    output logic [SW-1:0] sdram_addr,
    output logic          sdram_req,
    input  logic          sdram_ack,
    input  logic          data_rdy,
    input  logic [31:0]   sdram_din
);

    localparam int LB = (DW == 8) ? 2 : 1;
    localparam int TW = AW - LB;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]    state;
    logic [1:0]    valid;
    logic          victim;
    logic          discard;
    logic [TW-1:0] tag0, tag1, req_tag;
    logic [31:0]   data0, data1;

    logic [TW-1:0] atag;
    logic [LB-1:0] wsel;
    logic          hit0, hit1, hit, fill;
    logic [31:0]   line_sel, line_sh;
    logic [SW-1:0] tag_addr;

    assign atag = addr[AW-1:LB];
    assign wsel = addr[LB-1:0];
    assign hit0 = valid[0] && (tag0 == atag);
    assign hit1 = valid[1] && (tag1 == atag);
    assign hit  = addr_ok && (hit0 || hit1);
    assign data_ok = hit;

    // Entry 0 is the default source so a double match resolves to it
    always_comb begin
        line_sel = (hit1 && !hit0) ? data1 : data0;
        line_sh  = line_sel >> (32'(wsel) * DW);
        dout     = line_sh[DW-1:0];
    end

    // Each line holds two 16-bit SDRAM words, hence the tag is scaled by 2
    assign tag_addr = SW'({atag, 1'b0});

    assign fill = data_rdy && ((state == S_WAIT) || (state == S_REQ && sdram_ack));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            valid      <= 2'b00;
            victim     <= 1'b0;
            discard    <= 1'b0;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            req_tag    <= '0;
            tag0       <= '0;
            tag1       <= '0;
            data0      <= '0;
            data1      <= '0;
        end else begin
            if (hit) victim <= hit0;

            case (state)
                S_IDLE: begin
                    if (addr_ok && !hit) begin
                        req_tag    <= atag;
                        sdram_addr <= offset + tag_addr;
                        sdram_req  <= 1'b1;
                        state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        state     <= data_rdy ? S_IDLE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (data_rdy) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // The line is written even when discarded; only its valid bit is withheld
            if (fill) begin
                if (victim) begin
                    data1 <= sdram_din;
                    tag1  <= req_tag;
                end else begin
                    data0 <= sdram_din;
                    tag0  <= req_tag;
                end
                victim <= ~victim;
            end

            if (clr)
                valid <= 2'b00;
            else if (fill && !discard)
                valid[victim] <= 1'b1;

            if (fill)
                discard <= 1'b0;
            else if (clr && state != S_IDLE)
                discard <= 1'b1;
        end
    end

endmodule

// File: doc/jtframe_rom_fetch.md
# jtframe_rom_fetch

Two-entry line cache between a CPU ROM port and one SDRAM read slot, sitting directly upstream of the CPU clock-enable wait logic. It turns a CPU address plus chip-select into an SDRAM line request and drives the `data_ok` flag that the wait logic uses as `rom_ok`. Hits return data in the same cycle; misses stall until the SDRAM slot delivers a 32-bit line.

## Interface
Parameters:
- `AW`, 16: CPU address width, in units of `DW` words.
- `DW`, 8: CPU data width, 8 or 16.
- `SW`, 22: SDRAM word-address width (16-bit SDRAM words).

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `clr`  in  1  synchronous cache invalidate
- `offset`  in  SW  SDRAM base address of this ROM region
- `addr`  in  AW  CPU address
- `addr_ok`  in  1  CPU chip-select; connects to the wait logic's `rom_cs`
- `dout`  out  DW  CPU data, combinational
- `data_ok`  out  1  `dout` is valid for `addr`, combinational; connects to `rom_ok`
- `sdram_addr`  out  SW  line request address, registered
- `sdram_req`  out  1  request, registered, held until ack
- `sdram_ack`  in  1  one-cycle pulse: request accepted
- `data_rdy`  in  1  one-cycle pulse: `sdram_din` is valid
- `sdram_din`  in  32  returned line

## Operation
- Line geometry: 32 bits per line, i.e. 4 words when DW=8 and 2 words when DW=16.
  - `LB` = 2 when DW=8; `LB` = 1 when DW=16.
  - Tag = `addr[AW-1:LB]`. Word select = `addr[LB-1:0]`.
  - Word 0 sits in `din[DW-1:0]`; higher words follow at ascending bit positions.
- Entries 0 and 1 each hold `valid`, `tag` and `data[31:0]`. A 1-bit `victim` pointer selects the entry to replace.
- `hit` = `addr_ok` && (entry0 hit || entry1 hit). An entry hits when it is valid and its tag equals the address tag. If both entries match, entry 0 wins.
- `data_ok` = `hit`. `dout` is the selected word of the hit entry. When there is no hit, `dout` comes from entry 0 and is don't-care.
- LRU update: on a registered cycle with a hit, `victim` is set to the entry that did not hit.
- FSM, three states:
  - IDLE:
    - On `addr_ok` && !`hit`: latch `req_tag` = address tag.
    - Drive `sdram_addr` = `offset` + (`req_tag` × 2), truncated to SW bits so it wraps modulo 2^SW.
    - Set `sdram_req` = 1 and go to REQ.
  - REQ:
    - Hold `sdram_req` and `sdram_addr` stable.
    - On `sdram_ack`: `sdram_req` = 0, go to WAIT.
    - If `data_rdy` arrives in the same cycle as `sdram_ack`, treat it as WAIT completion: fill the line and go to IDLE.
  - WAIT:
    - On `data_rdy`: write `sdram_din` and `req_tag` into entry `victim`, set its `valid`, toggle `victim`, go to IDLE.
    - The fill uses `req_tag` even if `addr` has changed since the request.
- `addr` or `addr_ok` changing during REQ/WAIT does not abort the request. IDLE re-evaluates the current address afterwards.
- `clr`:
  - Clears both `valid` bits in the same cycle.
  - If a request is in REQ or WAIT, it completes on the bus, but its fill leaves `valid` = 0. A `discard` flag is set here and cleared on return to IDLE.
  - `clr` coincident with `data_rdy`: `clr` wins and the entry stays invalid.
  - `victim` is unchanged by `clr`.
- `addr_ok` low: no requests are issued and `data_ok` = 0.

## Timing
- Reset values:
  - `valid` = 2'b00, `victim` = 0, state IDLE.
  - `sdram_req` = 0, `sdram_addr` = 0, `discard` = 0.
  - Hence `data_ok` = 0; `dout` is undefined.
- Hit latency: 0 cycles. `data_ok` rises combinationally in the same cycle as `addr_ok` or `addr`.
- Miss sequence:
  - Miss seen at edge E0; `sdram_req` is high after E0.
  - `sdram_ack` sampled at edge Ea drops `sdram_req` after Ea.
  - `data_rdy` sampled at edge Ed writes the entry; `data_ok` is high after Ed, provided `addr` still matches.
  - Minimum miss-to-`data_ok` is 2 edges, when ack and rdy coincide at E0+1.
- A new request cannot issue on the same edge the previous fill completes. IDLE takes at least one cycle.
- Reset asserted mid-request: `sdram_req` drops asynchronously and the cache is empty. A late `data_rdy` in IDLE is ignored.
- `data_rdy` outside WAIT/REQ is ignored. `sdram_ack` outside REQ is ignored.

## Test plan
- Reset, then DW=8, `offset`=0x100, `addr`=0x0005 with `addr_ok`=1:
  - `data_ok`=0, then `sdram_req`=1 with `sdram_addr`=0x102.
  - ack, then rdy with `din`=0x44332211: `data_ok`=1, `dout`=0x22.
  - Then `addr`=0x0007 gives `dout`=0x44 with 0 wait.
- Two lines filled (tags 1 and 3), then read tag 1, then miss on tag 5:
  - The fill replaces tag 3's entry.
  - Tag 1 still hits, and tag 3 now misses.
- `clr` pulse while in WAIT, then `data_rdy`:
  - FSM returns to IDLE with `data_ok`=0.
  - A new request for the same line is issued on the next edge.
- `sdram_ack` and `data_rdy` in the same cycle: a single fill, `sdram_req` low, `data_ok` high on the next cycle.
- `offset`=0x3FFFFF (SW=22) with tag 1: `sdram_addr`=0x000001, wrapped.
- DW=16, `addr`=0x0003, `din`=0xBEEFCAFE: `dout`=0xBEEF. Then `addr_ok`=0 gives `data_ok`=0 and no request.
